// File: rtl/vga_timing_gen_p.sv
// VGA raster timing generator: zero-latency pixel request coordinates, plus sync/blank/colour
// delayed to match a pixel source of PIPE_LAT ce-cycles latency.
module vga_timing_gen_p #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned CW       = 8
) (
    input  logic          vgaclk,
    input  logic          rst,
    input  logic          ce,
    output logic [10:0]   x,
    output logic [10:0]   y,
    output logic          line_start,
    output logic          frame_start,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_b,
    output logic          sync_b,
    output logic [CW-1:0] vga_r,
    output logic [CW-1:0] vga_g,
    output logic [CW-1:0] vga_b,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned CNT_W    = 11;
    localparam int unsigned CMP_W    = 12;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Reject configurations the counters and delay line cannot represent
    if (PIPE_LAT > 7) begin : g_bad_lat
        $error("vga_timing_gen_p: PIPE_LAT must be 0..7");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_timing_gen_p: H_TOTAL and V_TOTAL must not exceed 2048");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $error("vga_timing_gen_p: sync widths must be non-zero");
    end

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             h_last;
    logic             v_last;

    assign h_last = (hcnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (vcnt == CNT_W'(V_TOTAL - 1));

    // Raster counters and frame counter
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            frame_cnt <= '0;
        end else if (ce) begin
            if (h_last) begin
                hcnt <= '0;
                if (v_last) begin
                    vcnt      <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    vcnt <= vcnt + CNT_W'(1);
                end
            end else begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

    assign x           = hcnt;
    assign y           = vcnt;
    assign line_start  = (hcnt == '0);
    assign frame_start = (hcnt == '0) && (vcnt == '0);

    // Widened compares so an end bound of exactly 2048 still decodes correctly
    logic [CMP_W-1:0] hc_w;
    logic [CMP_W-1:0] vc_w;
    logic             vis_raw;
    logic             hs_raw;
    logic             vs_raw;
    logic [2:0]       raw;
    logic [2:0]       del;

    assign hc_w    = {1'b0, hcnt};
    assign vc_w    = {1'b0, vcnt};
    assign vis_raw = (hc_w < CMP_W'(H_ACTIVE)) && (vc_w < CMP_W'(V_ACTIVE));
    assign hs_raw  = (hc_w >= CMP_W'(HS_START)) && (hc_w < CMP_W'(HS_END));
    assign vs_raw  = (vc_w >= CMP_W'(VS_START)) && (vc_w < CMP_W'(VS_END));
    assign raw     = {vis_raw, hs_raw, vs_raw};

    // Delay line matching the pixel source latency; {visible, hs, vs}
    if (PIPE_LAT == 0) begin : g_nopipe
        assign del = raw;
    end else begin : g_pipe
        logic [2:0] stage [PIPE_LAT];

        always_ff @(posedge vgaclk) begin
            if (rst) begin
                for (int i = 0; i < int'(PIPE_LAT); i++) begin
                    stage[i] <= '0;
                end
            end else if (ce) begin
                stage[0] <= raw;
                for (int i = 1; i < int'(PIPE_LAT); i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign del = stage[PIPE_LAT-1];
    end

    // Pin register: sync polarity applied here, colour gated by the aligned visible bit
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            hsync   <= ~HS_POL;
            vsync   <= ~VS_POL;
            blank_b <= 1'b0;
            sync_b  <= 1'b1;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
        end else if (ce) begin
            hsync   <= del[1] ? HS_POL : ~HS_POL;
            vsync   <= del[0] ? VS_POL : ~VS_POL;
            blank_b <= del[2];
            sync_b  <= ~(del[1] | del[0]);
            vga_r   <= del[2] ? r_in : '0;
            vga_g   <= del[2] ? g_in : '0;
            vga_b   <= del[2] ? b_in : '0;
        end
    end

endmodule
